adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
//   Parametrised, segmented, pipelined signed adder with valid/ready flow control,
//   carry-out, overflow and zero flags, and optional saturation.
//   Replaces single-cycle adders on wide datapaths. Splits the carry chain into
//   SEGS registered segments to meet timing. Sits between an operand producer
//   and a result consumer, both using valid/ready handshakes.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be a multiple of SEGS
//   SEGS   4   pipeline stages; each stage adds WIDTH/SEGS bits (1 = one-stage adder)
//   SAT    0   1: clamp result to signed max/min on overflow; 0: wrap
// PORTS
//   clk        in   1      single clock; all state on posedge clk
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands x, y, cin valid
//   in_ready   out  1      pipeline accepts operands this cycle
//   x          in   WIDTH  signed operand
//   y          in   WIDTH  signed operand
//   cin        in   1      carry-in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  signed x+y+cin (wrapped, or clamped when SAT=1)
//   cout       out  1      unsigned carry out of bit WIDTH-1
//   ovf        out  1      signed overflow of the unclamped sum
//   zero       out  1      sum == 0, taken after any clamping
// BEHAVIOUR
//   - Interface: one clock, clk. Reset is asynchronous and active-high, on rst.
//   - Reset: all stage valid bits, data/carry registers and outputs go to 0
//     (out_valid=0, sum=0, cout=0, ovf=0, zero=0).
//   - Reset asserted mid-operation discards all in-flight items. No partial result
//     appears after reset is released.
//   - Global advance: adv = ~out_valid | out_ready; in_ready = adv (combinational).
//   - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   - When adv=1, every stage shifts one position. Bubbles propagate and are not
//     collapsed.
//   - When adv=0, all stages hold. sum/cout/ovf/zero stay stable while out_valid=1.
//   - Latency: exactly SEGS cycles from input transfer to out_valid with no stalls.
//     Throughput is 1 result/cycle when out_ready is held high.
//   - Stage k (0..SEGS-1) adds segment k of x and y (bits k*SW +: SW, SW=WIDTH/SEGS).
//     Its carry-in is cin for k=0, otherwise the registered carry from stage k-1.
//   - Upper operand segments are delay-aligned through stage registers.
//     Lower result segments are carried forward.
//   - Final stage computes the following:
//     - cout: carry out of the top segment.
//     - ovf = (x[W-1]==y[W-1]) & (raw[W-1]!=x[W-1]), using the delayed operand sign bits.
//   - SAT=1 and ovf=1: sum = x sign ? {1'b1,{W-1{0}}} : {1'b0,{W-1{1}}}.
//     cout and ovf report the raw values.
//   - Wrap-around (SAT=0): modulo 2^WIDTH, e.g. 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
//   - Simultaneous input and output transfer in the same cycle is legal and is the
//     normal streaming case.
//   - in_valid=0 with adv=1 inserts a bubble. x/y/cin are don't-care when in_valid=0.
// STRUCTURE
//   - Package adder_pkg:
//     - function seg_w(WIDTH,SEGS)
//     - functions sat_max(W)/sat_min(W)
//     - typedef for the per-stage record {valid, carry, operand hi-parts, partial sum}
//     - elaboration check WIDTH % SEGS == 0
//   - Sub-module adder_seg: one SW-bit segment adder, (a,b,ci) -> (s,co), combinational.
//     Instantiated SEGS times in a generate loop. Pipeline registers and flow control
//     live in adder_pipe.
// TESTING (W=32, SEGS=4 unless noted)
//   1 Reset: assert rst async mid-stream with 3 items in flight.
//     -> outputs 0 immediately. After release, no stale out_valid.
//   2 Streaming: 100 random x,y,cin back-to-back, out_ready=1.
//     -> results in order, each exactly 4 cycles after accept, matching a model.
//   3 Carry ripple: x=0xFFFFFFFF, y=0, cin=1.
//     -> sum=0, cout=1, ovf=0, zero=1. Carry crosses all 4 segments.
//   4 Overflow: x=0x7FFFFFFF, y=1, cin=0.
//     -> SAT=0: sum=0x80000000, ovf=1.
//     -> SAT=1: sum=0x7FFFFFFF, ovf=1.
//     x=0x80000000, y=0xFFFFFFFF, SAT=1.
//     -> sum=0x80000000, ovf=1, cout=1.
//   5 Backpressure: random out_ready duty 30%, random in_valid gaps.
//     -> no loss or duplication. in_ready==~out_valid|out_ready every cycle.
//     -> outputs stable while stalled.
//   6 SEGS=1 and SEGS=8: repeat scenario 2.
//     -> latency 1 and 8 respectively, identical results.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder.
//   seg_w / seg_ok    : segment width and legality of a WIDTH/SEGS split
//   sat_max / sat_min : signed clamp values for a W-bit result, returned
//                       right-aligned in a MAX_W-bit vector
//   stage_ctl_t       : control half of a pipeline stage record. The data
//                       half (operand hi-parts, partial sum) is sized by
//                       WIDTH/SEGS inside adder_pipe.
package adder_pkg;

  localparam int MAX_W = 256;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int seg_w(int width, int segs);
    return (segs > 0) ? width / segs : width;
  endfunction

  function automatic bit seg_ok(int width, int segs);
    return (segs > 0) && (width > 0) && (width % segs == 0);
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(int w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
//   Input side : in_valid, in_ready, x, y, cin
//   Output side: out_valid, out_ready, sum, cout, ovf, zero
//   slave  modport: the adder itself
//   master modport: the producer/consumer environment around it
interface adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, x, y, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

  modport master (
    output in_valid, x, y, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/adder_seg.sv
// One SW-bit slice of the segmented adder, purely combinational.
//   a, b : segment operands
//   ci   : carry into the segment
//   s    : segment sum
//   co   : carry out of the segment
module adder_seg #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};

endmodule

// File: rtl/adder_pipe.sv
// Segmented, pipelined signed adder with valid/ready flow control.
// The carry chain is cut into SEGS registered slices of WIDTH/SEGS bits.
// Each pipeline register carries the not-yet-added operand bits
// (right-aligned, so every stage works on bits [SW-1:0]) and the finished
// lower sum slices (filled from the top down, so after the last register
// they sit in natural order). The final slice derives cout/ovf, applies
// optional saturation and the zero flag into the output register.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : adder_pipe_if slave (operands in, result + flags out)
// Whole pipeline advances together: adv = ~out_valid | out_ready.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4,
  parameter bit SAT   = 1'b0
) (
  input logic         clk,
  input logic         rst,
  adder_pipe_if.slave bus
);

  localparam int               SW   = seg_w(WIDTH, SEGS);
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  if (!seg_ok(WIDTH, SEGS)) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a positive multiple of SEGS");
  end

  logic          adv;
  logic [SW-1:0] seg_a  [SEGS];
  logic [SW-1:0] seg_b  [SEGS];
  logic [SW-1:0] seg_s  [SEGS];
  logic          seg_ci [SEGS];
  logic          seg_co [SEGS];

  logic             fin_valid;
  logic [WIDTH-1:0] fin_raw;
  logic             fin_xs;
  logic             fin_ys;
  logic             fin_cout;
  logic             fin_ovf;
  logic [WIDTH-1:0] fin_sum;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic             out_zero_q;

  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    adder_seg #(.SW(SW)) u_seg (
      .a  (seg_a[k]),
      .b  (seg_b[k]),
      .ci (seg_ci[k]),
      .s  (seg_s[k]),
      .co (seg_co[k])
    );
  end

  if (SEGS == 1) begin : g_single
    always_comb begin
      seg_a[0]  = bus.x;
      seg_b[0]  = bus.y;
      seg_ci[0] = bus.cin;
    end

    assign fin_valid = bus.in_valid;
    assign fin_raw   = seg_s[0];
  end else begin : g_pipe
    localparam int PW = WIDTH - SW;

    typedef struct packed {
      stage_ctl_t       ctl;
      logic [PW-1:0]    xh;
      logic [PW-1:0]    yh;
      logic [PW-1:0]    ps;
    } stage_t;

    stage_t st   [SEGS-1];
    stage_t st_d [SEGS-1];

    always_comb begin
      for (int k = 0; k < SEGS; k++) begin
        seg_a[k]  = '0;
        seg_b[k]  = '0;
        seg_ci[k] = 1'b0;
      end
      seg_a[0]  = bus.x[SW-1:0];
      seg_b[0]  = bus.y[SW-1:0];
      seg_ci[0] = bus.cin;
      for (int k = 1; k < SEGS; k++) begin
        seg_a[k]  = st[k-1].xh[SW-1:0];
        seg_b[k]  = st[k-1].yh[SW-1:0];
        seg_ci[k] = st[k-1].ctl.carry;
      end
    end

    always_comb begin
      for (int k = 0; k < SEGS - 1; k++) begin
        st_d[k] = '0;
      end
      st_d[0].ctl.valid = bus.in_valid;
      st_d[0].ctl.carry = seg_co[0];
      st_d[0].xh        = bus.x[WIDTH-1:SW];
      st_d[0].yh        = bus.y[WIDTH-1:SW];
      st_d[0].ps        = PW'(seg_s[0]) << (PW - SW);
      for (int k = 1; k < SEGS - 1; k++) begin
        st_d[k].ctl.valid = st[k-1].ctl.valid;
        st_d[k].ctl.carry = seg_co[k];
        st_d[k].xh        = st[k-1].xh >> SW;
        st_d[k].yh        = st[k-1].yh >> SW;
        // newest slice enters at the top, older slices slide down
        st_d[k].ps        = (st[k-1].ps >> SW) | (PW'(seg_s[k]) << (PW - SW));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < SEGS - 1; k++) begin
          st[k] <= '0;
        end
      end else if (adv) begin
        for (int k = 0; k < SEGS - 1; k++) begin
          st[k] <= st_d[k];
        end
      end
    end

    assign fin_valid = st[SEGS-2].ctl.valid;
    assign fin_raw   = {seg_s[SEGS-1], st[SEGS-2].ps};
  end

  // the top slice's operands still hold the original sign bits
  always_comb begin
    fin_xs   = seg_a[SEGS-1][SW-1];
    fin_ys   = seg_b[SEGS-1][SW-1];
    fin_cout = seg_co[SEGS-1];
    fin_ovf  = (fin_xs == fin_ys) & (fin_raw[WIDTH-1] != fin_xs);
    fin_sum  = fin_raw;
    if (SAT && fin_ovf) begin
      fin_sum = fin_xs ? SMIN : SMAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q <= fin_valid;
      out_sum_q   <= fin_sum;
      out_cout_q  <= fin_cout;
      out_ovf_q   <= fin_ovf;
      out_zero_q  <= (fin_sum == '0);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = out_sum_q;
  assign bus.cout      = out_cout_q;
  assign bus.ovf       = out_ovf_q;
  assign bus.zero      = out_zero_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe. Four instances share one operand stream:
//   dut0 SEGS=4 SAT=0, dut1 SEGS=4 SAT=1, dut2 SEGS=1 SAT=0, dut3 SEGS=8 SAT=0
// Each has its own out_ready and its own expected-result FIFO filled from an
// arithmetic reference model at the moment it accepts an operand.
module tb_adder_pipe;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] x;
  logic [31:0] y;
  logic        cin;
  logic        out_rdy  [4];
  logic        o_iready [4];
  logic        o_valid  [4];
  logic [31:0] o_sum    [4];
  logic        o_cout   [4];
  logic        o_ovf    [4];
  logic        o_zero   [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  res_t exp_mem [4][256];
  int   acc_cyc [4][256];
  int   wr [4];
  int   rd [4];
  bit   have_out [4];
  bit   have_exp [4];
  res_t got  [4];
  res_t expv [4];
  int   lat  [4];
  bit   ir_ok   [4];
  bit   stab_ok [4];
  bit   prev_stall [4];
  res_t prev_res   [4];

  adder_pipe_if #(.WIDTH(32)) if0 ();
  adder_pipe_if #(.WIDTH(32)) if1 ();
  adder_pipe_if #(.WIDTH(32)) if2 ();
  adder_pipe_if #(.WIDTH(32)) if3 ();

  adder_pipe #(.WIDTH(32), .SEGS(4), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  adder_pipe #(.WIDTH(32), .SEGS(4), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  adder_pipe #(.WIDTH(32), .SEGS(1), .SAT(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  adder_pipe #(.WIDTH(32), .SEGS(8), .SAT(1'b0)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if2.in_valid = in_valid;  assign if3.in_valid = in_valid;
  assign if0.x = x;  assign if1.x = x;  assign if2.x = x;  assign if3.x = x;
  assign if0.y = y;  assign if1.y = y;  assign if2.y = y;  assign if3.y = y;
  assign if0.cin = cin;  assign if1.cin = cin;  assign if2.cin = cin;  assign if3.cin = cin;
  assign if0.out_ready = out_rdy[0];  assign if1.out_ready = out_rdy[1];
  assign if2.out_ready = out_rdy[2];  assign if3.out_ready = out_rdy[3];

  assign o_iready[0] = if0.in_ready;  assign o_valid[0] = if0.out_valid;
  assign o_sum[0] = if0.sum;  assign o_cout[0] = if0.cout;
  assign o_ovf[0] = if0.ovf;  assign o_zero[0] = if0.zero;
  assign o_iready[1] = if1.in_ready;  assign o_valid[1] = if1.out_valid;
  assign o_sum[1] = if1.sum;  assign o_cout[1] = if1.cout;
  assign o_ovf[1] = if1.ovf;  assign o_zero[1] = if1.zero;
  assign o_iready[2] = if2.in_ready;  assign o_valid[2] = if2.out_valid;
  assign o_sum[2] = if2.sum;  assign o_cout[2] = if2.cout;
  assign o_ovf[2] = if2.ovf;  assign o_zero[2] = if2.zero;
  assign o_iready[3] = if3.in_ready;  assign o_valid[3] = if3.out_valid;
  assign o_sum[3] = if3.sum;  assign o_cout[3] = if3.cout;
  assign o_ovf[3] = if3.ovf;  assign o_zero[3] = if3.zero;

  always #5 clk = ~clk;

  function automatic int seg_of(int i);
    case (i)
      2:       return 1;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic bit sat_of(int i);
    return (i == 1);
  endfunction

  // Reference: exact integer sum, then wrap/clamp.
  function automatic res_t model(logic [31:0] a, logic [31:0] b, logic c, bit sat);
    res_t        r;
    longint      sa;
    logic [32:0] u;
    sa     = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    u      = {1'b0, a} + {1'b0, b} + {32'd0, c};
    r.cout = u[32];
    r.ovf  = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
    if (sat && r.ovf) r.sum = (sa > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else              r.sum = u[31:0];
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom % 5)
      0:       return 32'h7FFF_FFFF - ($urandom % 4);
      1:       return 32'h8000_0000 + ($urandom % 4);
      2:       return 32'hFFFF_FFFF - ($urandom % 2);
      default: return $urandom;
    endcase
  endfunction

  // Advance one cycle: sample handshakes at negedge, collect transfers.
  task automatic tick();
    res_t cur;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cur        = '{o_sum[i], o_cout[i], o_ovf[i], o_zero[i]};
      ir_ok[i]   = (o_iready[i] === (!o_valid[i] || out_rdy[i]));
      stab_ok[i] = !prev_stall[i] || (o_valid[i] === 1'b1 && cur === prev_res[i]);
      prev_stall[i] = o_valid[i] && !out_rdy[i];
      prev_res[i]   = cur;
      have_out[i] = 1'b0;
      have_exp[i] = 1'b0;
      if (o_valid[i] === 1'b1 && out_rdy[i]) begin
        have_out[i] = 1'b1;
        got[i]      = cur;
        if (rd[i] != wr[i]) begin
          have_exp[i] = 1'b1;
          expv[i]     = exp_mem[i][rd[i] % 256];
          lat[i]      = cyc - acc_cyc[i][rd[i] % 256];
          rd[i]++;
        end
      end
      if (in_valid && o_iready[i] === 1'b1) begin
        exp_mem[i][wr[i] % 256] = model(x, y, cin, sat_of(i));
        acc_cyc[i][wr[i] % 256] = cyc;
        wr[i]++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    // power-on reset
    #12;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({o_valid[i], o_sum[i], o_cout[i], o_ovf[i], o_zero[i]} !== 36'd0) begin
        errors++;
        $display("FAIL reset_init dut%0d got v=%b sum=%h c=%b o=%b z=%b required all 0",
                 i, o_valid[i], o_sum[i], o_cout[i], o_ovf[i], o_zero[i]);
      end
    end
    rst = 1'b0;
    // three items in flight, then async reset mid-cycle
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1; x = rand_op(); y = rand_op(); cin = 1'($urandom % 2);
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({o_valid[i], o_sum[i], o_cout[i], o_ovf[i], o_zero[i]} !== 36'd0) begin
        errors++;
        $display("FAIL reset_async dut%0d got v=%b sum=%h c=%b o=%b z=%b required all 0",
                 i, o_valid[i], o_sum[i], o_cout[i], o_ovf[i], o_zero[i]);
      end
      rd[i] = wr[i];
      prev_stall[i] = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (o_valid[i] !== 1'b0 || have_out[i]) begin
          errors++;
          $display("FAIL reset_stale dut%0d cycle %0d got out_valid=%b required 0", i, t, o_valid[i]);
        end
      end
    end
  endtask

  task automatic test_stream(int n);
    int nout [4];
    for (int i = 0; i < 4; i++) begin
      nout[i] = 0;
      out_rdy[i] = 1'b1;
    end
    for (int t = 0; t < n + 12; t++) begin
      if (t < n) begin
        in_valid = 1'b1; x = rand_op(); y = rand_op(); cin = 1'($urandom % 2);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (have_out[i]) begin
          nout[i]++;
          checks++;
          if (!have_exp[i]) begin
            errors++;
            $display("FAIL stream_extra dut%0d got sum=%h required no result", i, got[i].sum);
          end else if (got[i] !== expv[i]) begin
            errors++;
            $display("FAIL stream_data dut%0d got %h/%b/%b/%b required %h/%b/%b/%b", i,
                     got[i].sum, got[i].cout, got[i].ovf, got[i].zero,
                     expv[i].sum, expv[i].cout, expv[i].ovf, expv[i].zero);
          end
          if (have_exp[i]) begin
            checks++;
            if (lat[i] != seg_of(i)) begin
              errors++;
              $display("FAIL stream_latency dut%0d got %0d required %0d", i, lat[i], seg_of(i));
            end
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nout[i] != n || rd[i] != wr[i]) begin
        errors++;
        $display("FAIL stream_count dut%0d got %0d results required %0d", i, nout[i], n);
      end
    end
  endtask

  task automatic test_corner(input string name, input logic [31:0] xv, input logic [31:0] yv,
                             input logic cv, input res_t ew, input res_t es);
    int   seen [4];
    res_t req;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 0;
      out_rdy[i] = 1'b1;
    end
    in_valid = 1'b1; x = xv; y = yv; cin = cv;
    tick();
    in_valid = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (have_out[i]) begin
          seen[i]++;
          req = sat_of(i) ? es : ew;
          checks++;
          if (got[i] !== req) begin
            errors++;
            $display("FAIL %s dut%0d got %h/%b/%b/%b required %h/%b/%b/%b", name, i,
                     got[i].sum, got[i].cout, got[i].ovf, got[i].zero,
                     req.sum, req.cout, req.ovf, req.zero);
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] != 1) begin
        errors++;
        $display("FAIL %s_count dut%0d got %0d results required 1", name, i, seen[i]);
      end
    end
  endtask

  task automatic test_backpressure(int ncyc);
    for (int t = 0; t < ncyc + 40; t++) begin
      if (t < ncyc) begin
        in_valid = ($urandom % 3 != 0); x = rand_op(); y = rand_op(); cin = 1'($urandom % 2);
        for (int i = 0; i < 4; i++) out_rdy[i] = ($urandom % 10 < 3);
      end else begin
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) out_rdy[i] = 1'b1;
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (!ir_ok[i]) begin
          errors++;
          $display("FAIL bp_in_ready dut%0d cycle %0d got %b required ~out_valid|out_ready",
                   i, t, o_iready[i]);
        end
        checks++;
        if (!stab_ok[i]) begin
          errors++;
          $display("FAIL bp_stable dut%0d cycle %0d got v=%b sum=%h required held v=1 sum=%h",
                   i, t, o_valid[i], o_sum[i], prev_res[i].sum);
        end
        if (have_out[i]) begin
          checks++;
          if (!have_exp[i]) begin
            errors++;
            $display("FAIL bp_extra dut%0d got sum=%h required no result", i, got[i].sum);
          end else if (got[i] !== expv[i]) begin
            errors++;
            $display("FAIL bp_data dut%0d got %h/%b/%b/%b required %h/%b/%b/%b", i,
                     got[i].sum, got[i].cout, got[i].ovf, got[i].zero,
                     expv[i].sum, expv[i].cout, expv[i].ovf, expv[i].zero);
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd[i] != wr[i]) begin
        errors++;
        $display("FAIL bp_loss dut%0d got %0d results required %0d", i, rd[i], wr[i]);
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_rdy[i] = 1'b1; wr[i] = 0; rd[i] = 0; prev_stall[i] = 1'b0;
    end
    test_reset();
    test_stream(100);
    test_corner("carry_ripple", 32'hFFFF_FFFF, 32'h0, 1'b1,
                '{32'h0, 1'b1, 1'b0, 1'b1}, '{32'h0, 1'b1, 1'b0, 1'b1});
    test_corner("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0,
                '{32'h8000_0000, 1'b0, 1'b1, 1'b0}, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    test_corner("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
                '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}, '{32'h8000_0000, 1'b1, 1'b1, 1'b0});
    test_backpressure(400);
    test_stream(50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
